// File: rtl/booth_iter_mult_if.sv
// Operand/result handshake bundle for booth_iter_mult.
// The master drives operands and out_ready; the slave (the multiplier) returns the product.
interface booth_iter_mult_if #(
    parameter int W = 16
);
    localparam int DW = $clog2(W / 2) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    product;
    logic [DW-1:0]     digits;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, digits, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, digits, busy
    );
endinterface

// File: rtl/booth_iter_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit of the signed operand a per RUN cycle.
// Optional macro BOOTH_EARLY_TERM_EN stops RUN once the remaining digits of a are all zero.

// Radix-4 Booth partial-product generator. pp is W+1 bits so that 2*b and -2*b of the
// most negative b stay exact; a negative digit is returned as ~|x| with cpl=1.
module booth_pp #(
    parameter int W    = 16,
    parameter bit PIPE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   booth_bits,
    input  logic [W-1:0] b,
    output logic [W:0]   pp,
    output logic         cpl
);
    logic [W:0] pp_c;
    logic       cpl_c;
    logic [W:0] pp_q;
    logic       cpl_q;
    logic [W:0] b_x1;
    logic [W:0] b_x2;

    assign b_x1 = {b[W-1], b};
    assign b_x2 = {b, 1'b0};

    always_comb begin
        // NOTE: every output gets a default before the case, so no latch can be inferred.
        pp_c  = '0;
        cpl_c = 1'b0;
        case (booth_bits)
            3'b001, 3'b010: pp_c = b_x1;
            3'b011:         pp_c = b_x2;
            3'b100: begin
                pp_c  = ~b_x2;
                cpl_c = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_c  = ~b_x1;
                cpl_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            pp_q  <= '0;
            cpl_q <= 1'b0;
        end else begin
            pp_q  <= pp_c;
            cpl_q <= cpl_c;
        end
    end

    assign pp  = PIPE ? pp_q  : pp_c;
    assign cpl = PIPE ? cpl_q : cpl_c;
endmodule

module booth_iter_mult #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    booth_iter_mult_if.slave bus
);
    localparam int ND = W / 2;
    localparam int IW = $clog2(ND);
    localparam int DW = IW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [IW-1:0]  idx;
    logic [2*W-1:0] product_q;
    logic [DW-1:0]  digits_q;

    logic [W:0]     a_ext;
    logic [2:0]     booth_bits;
    logic [W:0]     pp;
    logic           cpl;
    logic [2*W-1:0] term;
    logic           last_digit;

    // a[-1] is the implicit zero below the LSB.
    assign a_ext      = {a_reg, 1'b0};
    assign booth_bits = a_ext[{idx, 1'b0} +: 3];

    booth_pp #(
        .W   (W),
        .PIPE(1'b0)
    ) u_pp (
        .clk       (clk),
        .rst       (rst),
        .booth_bits(booth_bits),
        .b         (b_reg),
        .pp        (pp),
        .cpl       (cpl)
    );

    // Digit i has weight 4^i; everything wraps modulo 2^(2W).
    assign term     = {{(W-1){pp[W]}}, pp} + {{(2*W-1){1'b0}}, cpl};
    assign acc_next = acc + (term << {idx, 1'b0});

`ifdef BOOTH_EARLY_TERM_EN
    logic [W-1:0] hi_bits;

    // Remaining digits are zero once a[W-1:2i+1] is pure sign extension.
    assign hi_bits    = W'($signed(a_reg) >>> {idx, 1'b1});
    assign last_digit = (hi_bits == '0) || (&hi_bits);
`else
    assign last_digit = (idx == IW'(ND - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_digit)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            product_q <= '0;
            digits_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last_digit) begin
                        product_q <= acc_next;
                        digits_q  <= DW'(idx) + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.product   = product_q;
    assign bus.digits    = digits_q;
endmodule

// File: tb/tb_booth_iter_mult.sv
// Self-checking bench for booth_iter_mult: directed table, corner sequences and random
// operands against an arithmetic reference (a*b, digit count from the magnitude of a).
module tb_booth_iter_mult;
    localparam int W  = 16;
    localparam int DW = $clog2(W / 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    booth_iter_mult_if #(.W(W)) bus ();

    booth_iter_mult #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             dg_full;
        int             dg_et;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint p;
        p = longint'($signed(av)) * longint'($signed(bv));
        return p[2*W-1:0];
    endfunction

    // Digits needed: smallest k+1 such that a fits in a (2k+2)-bit signed number.
    function automatic int model_digits(input logic [W-1:0] av);
`ifdef BOOTH_EARLY_TERM_EN
        int sa;
        sa = int'($signed(av));
        for (int k = 0; k < W / 2; k++) begin
            if (sa >= -(1 <<< (2 * k + 1)) && sa < (1 <<< (2 * k + 1))) return k + 1;
        end
        return W / 2;
`else
        return W / 2;
`endif
    endfunction

    // Handshake one operand pair and wait for out_valid; lat counts edges from the handshake edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            lat++;
            n++;
        end
        if (!bus.out_valid) to = 1'b1;
    endtask

    task automatic finish_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int             lat;
        bit             to;
        int             exp_dg;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] p0;
        int             hs;

        vecs[0] = '{16'd3,      16'd5,      32'h0000_000F, 8, 2};
        vecs[1] = '{16'd7,      16'hFFFD,   32'hFFFF_FFEB, 8, 2};
        vecs[2] = '{16'hFFFF,   16'hFFFF,   32'h0000_0001, 8, 1};
        vecs[3] = '{16'h8000,   16'h8000,   32'h4000_0000, 8, 8};
        vecs[4] = '{16'h7FFF,   16'h8000,   32'hC000_8000, 8, 8};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_product",   64'(bus.product),   64'd0);
        check("rst_digits",    64'(bus.digits),    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
`ifdef BOOTH_EARLY_TERM_EN
            exp_dg = vecs[i].dg_et;
`else
            exp_dg = vecs[i].dg_full;
`endif
            start_op(vecs[i].a, vecs[i].b, lat, to);
            check($sformatf("vec%0d_timeout", i), 64'(to),          64'd0);
            check($sformatf("vec%0d_product", i), 64'(bus.product), 64'(vecs[i].prod));
            check($sformatf("vec%0d_digits", i),  64'(bus.digits),  64'(exp_dg));
            check($sformatf("vec%0d_latency", i), 64'(lat),         64'(exp_dg + 1));
            finish_op();
            check($sformatf("vec%0d_idle", i),    64'(bus.in_ready), 64'd1);
        end

        // Back-pressure in DONE
        start_op(16'h1234, 16'h00AB, lat, to);
        check("bp_timeout", 64'(to), 64'd0);
        p0 = model_prod(16'h1234, 16'h00AB);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_product",   64'(bus.product),   64'(p0));
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        finish_op();
        check("bp_rel_in_ready",  64'(bus.in_ready),  64'd1);
        check("bp_rel_busy",      64'(bus.busy),      64'd0);
        check("bp_rel_out_valid", 64'(bus.out_valid), 64'd0);

        // in_valid held high, operands scrambled while busy
        @(negedge clk);
        bus.a        = 16'd11;
        bus.b        = 16'd13;
        bus.in_valid = 1'b1;
        hs = 0;
        for (int n = 0; n < 100; n++) begin
            if (bus.in_valid && bus.in_ready) hs++;
            if (bus.out_valid) break;
            if (bus.busy) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        check("hold_product",   64'(bus.product),   64'd143);
        check("hold_handshakes", 64'(hs),           64'd1);
        finish_op();

        // Reset in the middle of RUN
        @(negedge clk);
        bus.a        = 16'd100;
        bus.b        = 16'd200;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_product",   64'(bus.product),   64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        start_op(16'd2, 16'd2, lat, to);
        check("abort_next_timeout", 64'(to),          64'd0);
        check("abort_next_product", 64'(bus.product), 64'd4);
        finish_op();

        // Random operands against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (r % 4 == 1) ra = W'($urandom_range(0, 15));
            if (r % 4 == 2) ra = -W'($urandom_range(1, 40));
            start_op(ra, rb, lat, to);
            exp_dg = model_digits(ra);
            check("rnd_timeout", 64'(to),          64'd0);
            check("rnd_product", 64'(bus.product), 64'(model_prod(ra, rb)));
            check("rnd_digits",  64'(bus.digits),  64'(exp_dg));
            check("rnd_latency", 64'(lat),         64'(exp_dg + 1));
            finish_op();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
